xorshift_dice_gen: RTL

XORSHIFT_DICE_GEN -- requirements
Module: xorshift_dice_gen

---
 rtl/xorshift_dice_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/xorshift_dice_gen.sv
// Electronic die: a free-running xorshift PRNG, stepped on a divided tick, feeds a
// rejection-sampled digit to a 7-segment decoder, with an optional roll/spin/show sequence.
module xorshift_dice_gen #(
  parameter int STATE_W    = 32,
  parameter int SH_A       = 13,
  parameter int SH_B       = 17,
  parameter int SH_C       = 5,
  parameter int MAX_COUNT  = 1000,
  parameter int SEED_W     = 6,
  parameter int RANGE      = 16,
  parameter int OFFSET     = 0,
  parameter int SPIN_TICKS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] seed,
  input  logic              load,
  input  logic              mode,
  input  logic              roll,
  output logic [3:0]        digit,
  output logic [6:0]        segments,
  output logic              busy,
  output logic              valid
);

  typedef enum logic [1:0] {IDLE, SPIN, SHOW} fsm_t;

  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam int SPC_W = $clog2(SPIN_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [SPC_W-1:0] SPIN_LAST = SPC_W'(SPIN_TICKS - 1);
  localparam logic [4:0]       RANGE_V   = 5'(RANGE);
  localparam logic [3:0]       OFFSET_V  = 4'(OFFSET);

  fsm_t               fsm, fsm_nxt;
  logic [STATE_W-1:0] state, state_next, seed_ext, seed_safe;
  logic [CNT_W-1:0]   tick_cnt;
  logic [SPC_W-1:0]   spin_cnt;
  logic               tick, step_en, accept, spin_clr;

  // NOTE: blocking assignments are correct here -- each line consumes the previous
  // line's result within the same evaluation, which is what the step requires.
  function automatic logic [STATE_W-1:0] xs_step(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  // An all-zero state is a fixed point of xorshift, so it is replaced by 1.
  assign seed_ext   = STATE_W'(seed);
  assign seed_safe  = (seed_ext == '0) ? STATE_W'(1) : seed_ext;
  assign tick       = (tick_cnt == CNT_MAX);
  assign state_next = xs_step(state);
  assign step_en    = tick && (!mode || fsm == SPIN);
  assign accept     = ({1'b0, state_next[3:0]} < RANGE_V);
  assign busy       = mode && (fsm == SPIN);
  assign valid      = mode && (fsm == SHOW);

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    fsm_nxt  = fsm;
    spin_clr = 1'b0;
    if (load || !mode) begin
      fsm_nxt = IDLE;
    end else begin
      case (fsm)
        IDLE: if (roll) begin
          fsm_nxt  = SPIN;
          spin_clr = 1'b1;
        end
        SPIN: if (tick && spin_cnt == SPIN_LAST) fsm_nxt = SHOW;
        SHOW: if (roll) begin
          fsm_nxt  = SPIN;
          spin_clr = 1'b1;
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= seed_safe;
      tick_cnt <= '0;
      spin_cnt <= '0;
      digit    <= OFFSET_V;
    end else if (load) begin
      state    <= seed_safe;
      tick_cnt <= '0;
      spin_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (spin_clr)                 spin_cnt <= '0;
      else if (fsm == SPIN && tick) spin_cnt <= spin_cnt + 1'b1;
      // Out-of-range candidates are dropped so the accepted values stay uniform.
      if (step_en) begin
        state <= state_next;
        if (accept) digit <= state_next[3:0] + OFFSET_V;
      end
    end
  end

  always_comb begin
    segments = 7'b0000000;
    case (digit)
      4'h0: segments = 7'b0111111;
      4'h1: segments = 7'b0000110;
      4'h2: segments = 7'b1011011;
      4'h3: segments = 7'b1001111;
      4'h4: segments = 7'b1100110;
      4'h5: segments = 7'b1101101;
      4'h6: segments = 7'b1111101;
      4'h7: segments = 7'b0000111;
      4'h8: segments = 7'b1111111;
      4'h9: segments = 7'b1101111;
      4'hA: segments = 7'b1110111;
      4'hB: segments = 7'b1111100;
      4'hC: segments = 7'b0111001;
      4'hD: segments = 7'b1011110;
      4'hE: segments = 7'b1111001;
      4'hF: segments = 7'b1110001;
      default: segments = 7'b0000000;
    endcase
  end

endmodule
